aes_decipher_block: RTL and testbench
=====================================

Name: aes_decipher_block

Overview:
Iterative AES inverse-cipher round engine. It is the decrypt counterpart of the encipher round engine and uses the same key-memory and S-box interface style. The block walks the round counter downward from Nr to 0 and supplies `round` to the external key memory, which returns `round_key` combinationally in the same cycle. Inverse SubBytes is done one 32-bit word per cycle through an external inverse S-box (`sboxw` out, `new_sboxw` in). ShiftRows, MixColumns and AddRoundKey are computed internally in their inverse forms.

Parameters:
None. Round counts are fixed localparams: AES128 = 10, AES192 = 12, AES256 = 14.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
next  in  1  single-cycle start pulse; honoured only when ready=1
keylen  in  2  0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = treated as AES-128
round  out  4  current round-key index, driven to the key memory
round_key  in  128  round key for index `round`, valid in the same cycle
sboxw  out  32  word presented to the external inverse S-box
new_sboxw  in  32  combinational inverse S-box result for `sboxw`
block  in  128  ciphertext; sampled only in the INIT cycle
new_block  out  128  working state register; holds plaintext when ready=1
ready  out  1  1 = idle and result valid, 0 = busy

Behaviour:
- Reset values: w0..w3 = 0 (so new_block = 0), round = 0, sword_ctr = 0, ready = 1, FSM = IDLE, latched keylen = 0.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - On next=1: latch keylen; round_ctr <= Nr (10/12/14); ready <= 0; go to INIT.
  - next=0: no change.
- INIT (1 cycle):
  - state <= InvShiftRows(block ^ round_key), using key Nr.
  - round_ctr decrements; sword_ctr <= 0; go to SBOX.
- SBOX (4 cycles):
  - sboxw = w[sword_ctr]; word w[sword_ctr] <= new_sboxw; sword_ctr increments.
  - After sword_ctr = 3 has been processed, go to MAIN. sword_ctr wraps to 0.
  - Word order is w0 = bits 127:96 first, through w3 = bits 31:0.
- MAIN (1 cycle):
  - If round_ctr > 0: state <= InvShiftRows(InvMixColumns(state ^ round_key)); round_ctr decrements; go to SBOX.
  - If round_ctr = 0: state <= state ^ round_key (final round); ready <= 1; go to IDLE.
  - sword_ctr <= 0 in both cases.
- sboxw is 0 in every state other than SBOX.
- InvMixColumns, applied per 32-bit column b0..b3:
  - mb0 = 0e·b0 ^ 0b·b1 ^ 0d·b2 ^ 09·b3, and rotations for mb1..mb3.
  - Arithmetic is GF(2^8) multiplication modulo 0x11b, built from the xtime chain.
- InvShiftRows: row r rotates right by r bytes.
  - Output column 0 = {w0[31:24], w3[23:16], w2[15:8], w1[7:0]}, and so on.
- Latency: with next sampled at edge E, ready rises at edge E + 1 + 5·Nr.
  - That is E+51 for AES-128, E+61 for AES-192, E+71 for AES-256.
- Key indices requested, in order: Nr (INIT), then Nr-1 down to 1 (MAIN), then 0 (final).
- next while busy is ignored. A keylen change while busy is ignored because the value was latched at start.
- new_block holds the plaintext, unchanged, until the next accepted start.
- A reset asserted mid-operation aborts immediately and asynchronously to the reset values. After reset releases, the FSM is in IDLE and the next `next` starts a fresh operation.

Test Plan:
1. Reset -> ready=1, new_block=0, round=0, sboxw=0. Hold reset for 3 cycles while pulsing next -> state remains unchanged.
2. AES-128, FIPS-197 C.1: key 000102..0f, block 69c4e0d86a7b0430d8cdb78070b4c55a, next pulse -> ready rises at edge +51; new_block = 00112233445566778899aabbccddeeff; round sequence 10, 9, ..., 0.
3. AES-192, C.2: key 000102..17, block dda97ca4864cdfe06eaf70a0ec0d7191 -> ready at edge +61 with the same plaintext. Repeat with AES-256, C.3: key 000102..1f, block 8ea2b7ca516745bfeafc49904b496089 -> ready at edge +71 with the same plaintext.
4. During the C.1 run, pulse next at cycle 20 and switch keylen to 2 at cycle 30 -> result and latency are identical to scenario 2.
5. Assert reset at cycle 25 of a C.1 run, release, then restart with C.2 -> the C.2 plaintext is correct; there is no residue from the aborted run.
6. Back-to-back: pulse next in the same cycle ready rises, keylen=3, C.1 vectors -> the run is treated as AES-128 (ready at edge +51, plaintext correct). Check sboxw=0 outside SBOX and a 4-cycle SBOX burst per round.

Source files
------------

// File: rtl/aes_decipher_block_if.sv
// Bus between the AES inverse-cipher round engine and its environment.
// The environment (master) supplies start control, the ciphertext, the
// round key for the requested index and the inverse S-box result.
// The engine (slave) drives the key index, the S-box word and the result.
interface aes_decipher_block_if;
   logic         next;
   logic [1:0]   keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   modport master (
      output next, keylen, round_key, new_sboxw, block,
      input  round, sboxw, new_block, ready
   );

   modport slave (
      input  next, keylen, round_key, new_sboxw, block,
      output round, sboxw, new_block, ready
   );
endinterface

// File: rtl/aes_decipher_block.sv
// Iterative AES inverse-cipher round engine.
// Walks the round counter downward from Nr to 0. The key memory returns
// the round key for the current index in the same cycle. Inverse SubBytes
// goes one word per cycle through an external inverse S-box; the inverse
// ShiftRows, MixColumns and AddRoundKey steps are done internally.
module aes_decipher_block (
   input logic                 clk,
   input logic                 reset,
   aes_decipher_block_if.slave bus
);

   localparam logic [3:0] AES128_ROUNDS = 4'd10;
   localparam logic [3:0] AES192_ROUNDS = 4'd12;
   localparam logic [3:0] AES256_ROUNDS = 4'd14;

   typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

   state_t       state_q;
   logic [127:0] block_q;
   logic [3:0]   roundCtr_q;
   logic [1:0]   swordCtr_q;
   logic         ready_q;

   // Encoding 3 is not a real key size and runs as AES-128.
   function automatic logic [3:0] numRounds(input logic [1:0] kl);
      case (kl)
         2'd1:    numRounds = AES192_ROUNDS;
         2'd2:    numRounds = AES256_ROUNDS;
         default: numRounds = AES128_ROUNDS;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant k using the xtime chain b, 2b, 4b, 8b.
   function automatic logic [7:0] gfMul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      gfMul = (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
              (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [31:0] invMixWord(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      b0 = w[31:24];
      b1 = w[23:16];
      b2 = w[15:8];
      b3 = w[7:0];
      invMixWord = {
         gfMul(b0, 4'he) ^ gfMul(b1, 4'hb) ^ gfMul(b2, 4'hd) ^ gfMul(b3, 4'h9),
         gfMul(b0, 4'h9) ^ gfMul(b1, 4'he) ^ gfMul(b2, 4'hb) ^ gfMul(b3, 4'hd),
         gfMul(b0, 4'hd) ^ gfMul(b1, 4'h9) ^ gfMul(b2, 4'he) ^ gfMul(b3, 4'hb),
         gfMul(b0, 4'hb) ^ gfMul(b1, 4'hd) ^ gfMul(b2, 4'h9) ^ gfMul(b3, 4'he)
      };
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      invMixColumns = {invMixWord(s[127:96]), invMixWord(s[95:64]),
                       invMixWord(s[63:32]),  invMixWord(s[31:0])};
   endfunction

   // Row r of output column c comes from input column (c - r) mod 4.
   function automatic logic [127:0] invShiftRows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127 - 32*c - 8*row -: 8] = s[127 - 32*((c - row + 4) % 4) - 8*row -: 8];
         end
      end
      invShiftRows = r;
   endfunction

   // Round FSM with the working state, counters and ready flag.
   // The key length is captured into the round counter at start, so
   // later keylen changes cannot affect a run in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         block_q    <= '0;
         roundCtr_q <= '0;
         swordCtr_q <= '0;
         ready_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.next) begin
                  roundCtr_q <= numRounds(bus.keylen);
                  ready_q    <= 1'b0;
                  state_q    <= INIT;
               end
            end
            INIT: begin
               block_q    <= invShiftRows(bus.block ^ bus.round_key);
               roundCtr_q <= roundCtr_q - 4'd1;
               swordCtr_q <= '0;
               state_q    <= SBOX;
            end
            SBOX: begin
               block_q[{~swordCtr_q, 5'b0} +: 32] <= bus.new_sboxw;
               swordCtr_q <= swordCtr_q + 2'd1;
               if (swordCtr_q == 2'd3) begin
                  state_q <= MAIN;
               end
            end
            MAIN: begin
               swordCtr_q <= '0;
               if (roundCtr_q != 4'd0) begin
                  block_q    <= invShiftRows(invMixColumns(block_q ^ bus.round_key));
                  roundCtr_q <= roundCtr_q - 4'd1;
                  state_q    <= SBOX;
               end else begin
                  block_q <= block_q ^ bus.round_key;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.round     = roundCtr_q;
   assign bus.new_block = block_q;
   assign bus.ready     = ready_q;
   assign bus.sboxw     = (state_q == SBOX) ? block_q[{~swordCtr_q, 5'b0} +: 32] : 32'h0;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Testbench for the AES inverse-cipher round engine using the FIPS-197
// appendix C vectors. The bench provides the key memory (its own key
// expansion) and the inverse S-box (built from GF(2^8) inverses).
module tb_aes_decipher_block;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   aes_decipher_block_if bus();

   aes_decipher_block dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
   localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PLAIN  = 128'h00112233445566778899aabbccddeeff;

   typedef struct {
      logic [1:0]   keylen;
      logic [255:0] key;
      logic [127:0] block;
      logic [127:0] plain;
      int           latency;
      int           mode;     // 0 plain run, 1 next/keylen noise while busy, 2 reset abort
   } vec_t;

   logic [7:0]   sbox      [0:255];
   logic [7:0]   invSbox   [0:255];
   logic [127:0] roundKeys [0:15];

   int checks = 0;
   int errors = 0;

   // Key memory and inverse S-box both answer combinationally.
   assign bus.round_key = roundKeys[bus.round];
   assign bus.new_sboxw = {invSbox[bus.sboxw[31:24]], invSbox[bus.sboxw[23:16]],
                           invSbox[bus.sboxw[15:8]],  invSbox[bus.sboxw[7:0]]};

   function automatic logic [7:0] xt(input logic [7:0] b);
      xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      gmul = p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      rotl8 = d[15:8];
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      subWord = {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   // S-box = affine transform of the multiplicative inverse.
   task automatic buildSboxes();
      logic [7:0] inv, s, xb;
      for (int x = 0; x < 256; x++) begin
         xb  = 8'(x);
         inv = 8'h00;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
         end
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x]    = s;
         invSbox[s] = xb;
      end
   endtask

   // Standard key expansion; keylen 3 expands as AES-128.
   task automatic setKeys(input logic [255:0] key, input logic [1:0] kl);
      logic [31:0] w [0:59];
      logic [31:0] temp;
      logic [7:0]  rcon;
      int nk, nr;
      nk   = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
      nr   = nk + 6;
      rcon = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr + 1); i++) begin
         temp = w[i-1];
         if (i % nk == 0) begin
            temp = subWord({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end else if (nk > 6 && i % nk == 4) begin
            temp = subWord(temp);
         end
         w[i] = w[i-nk] ^ temp;
      end
      for (int r = 0; r < 16; r++) roundKeys[r] = '0;
      for (int r = 0; r <= nr; r++) roundKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
      end
   endtask

   // Starts one operation from a negedge and follows it cycle by cycle:
   // round index sequence, sboxw quiet outside the 4-cycle SBOX bursts,
   // latency to ready and the final plaintext.
   task automatic applyStimulus(input vec_t v, input int idx);
      int  latency, roundErr, sboxOutErr, burst, nr, t, expRound;
      bit  done, aborted, inSbox;
      nr         = (v.latency - 1) / 5;
      latency    = -1;
      roundErr   = 0;
      sboxOutErr = 0;
      burst      = 0;
      done       = 1'b0;
      aborted    = 1'b0;
      setKeys(v.key, v.keylen);
      bus.block  = v.block;
      bus.keylen = v.keylen;
      bus.next   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.next = 1'b0;
      t = 1;
      while (!done && t <= 200) begin
         if (bus.ready) begin
            latency = t - 1;
            done    = 1'b1;
         end else if (v.mode == 2 && t == 25) begin
            reset = 1'b1;
            #1;
            checkOutput($sformatf("vec%0d abort ready", idx),     128'(bus.ready),     128'd1);
            checkOutput($sformatf("vec%0d abort new_block", idx), bus.new_block,       128'd0);
            checkOutput($sformatf("vec%0d abort round", idx),     128'(bus.round),     128'd0);
            checkOutput($sformatf("vec%0d abort sboxw", idx),     128'(bus.sboxw),     128'd0);
            aborted = 1'b1;
            done    = 1'b1;
         end else begin
            expRound = nr - (t + 3) / 5;
            if (t > 5*nr + 1 || int'(bus.round) != expRound) roundErr++;
            inSbox = (t >= 2) && (((t + 3) % 5) < 4);
            if (inSbox) begin
               if (bus.sboxw != 32'h0) burst++;
            end else if (bus.sboxw != 32'h0) begin
               sboxOutErr++;
            end
            if (v.mode == 1) begin
               if (t == 20) bus.next = 1'b1;
               if (t == 21) bus.next = 1'b0;
               if (t == 30) bus.keylen = 2'd2;
            end
            @(negedge clk);
            t++;
         end
      end
      if (!aborted) begin
         checkOutput($sformatf("vec%0d latency", idx),         128'(latency),    128'(v.latency));
         checkOutput($sformatf("vec%0d plaintext", idx),       bus.new_block,    v.plain);
         checkOutput($sformatf("vec%0d round sequence", idx),  128'(roundErr),   128'd0);
         checkOutput($sformatf("vec%0d sboxw outside", idx),   128'(sboxOutErr), 128'd0);
         checkOutput($sformatf("vec%0d sbox burst words", idx), 128'(burst),     128'(4*nr));
      end
   endtask

   vec_t vectors [0:4];
   vec_t abortVec;
   vec_t restartVec;

   initial begin
      vectors[0] = '{2'd0, KEY128, CT128, PLAIN, 51, 0};
      vectors[1] = '{2'd1, KEY192, CT192, PLAIN, 61, 0};
      vectors[2] = '{2'd2, KEY256, CT256, PLAIN, 71, 0};
      vectors[3] = '{2'd0, KEY128, CT128, PLAIN, 51, 1};
      vectors[4] = '{2'd3, KEY128, CT128, PLAIN, 51, 0};
      abortVec   = '{2'd0, KEY128, CT128, PLAIN, 51, 2};
      restartVec = '{2'd1, KEY192, CT192, PLAIN, 61, 0};

      buildSboxes();
      for (int r = 0; r < 16; r++) roundKeys[r] = '0;
      bus.next   = 1'b0;
      bus.keylen = 2'd0;
      bus.block  = '0;
      reset      = 1'b1;

      // Reset values, then next pulses held off by reset.
      @(negedge clk);
      checkOutput("reset ready",     128'(bus.ready), 128'd1);
      checkOutput("reset new_block", bus.new_block,   128'd0);
      checkOutput("reset round",     128'(bus.round), 128'd0);
      checkOutput("reset sboxw",     128'(bus.sboxw), 128'd0);
      bus.block = CT128;
      bus.next  = 1'b1;
      repeat (3) @(negedge clk);
      bus.next  = 1'b0;
      checkOutput("reset hold ready",     128'(bus.ready), 128'd1);
      checkOutput("reset hold new_block", bus.new_block,   128'd0);
      checkOutput("reset hold round",     128'(bus.round), 128'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idle ready",     128'(bus.ready), 128'd1);
      checkOutput("idle new_block", bus.new_block,   128'd0);

      // Back-to-back table: each start is issued the cycle ready rises.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vectors[i], i);
      end

      // Result stays put while idle.
      repeat (5) @(negedge clk);
      checkOutput("hold new_block", bus.new_block,   PLAIN);
      checkOutput("hold ready",     128'(bus.ready), 128'd1);

      // Abort a C.1 run with reset, then restart with C.2.
      applyStimulus(abortVec, 5);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post abort ready", 128'(bus.ready), 128'd1);
      applyStimulus(restartVec, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
